fp_cmp_result_unit: RTL and testbench

//  Consumer side of the FP64 compare path. Takes the 16-bit condition vector and nan/snan

---
 rtl/fpCmpPkg.sv | 48 ++++
 rtl/fp_cmp_skid2.sv | 62 ++++++
 rtl/fp_cmp_result_unit.sv | 93 +++++++++
 tb/tb_fp_cmp_result_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpCmpPkg.sv
// fpCmpPkg: definitions shared by the FP64 compare unit and its result consumer.
//   - bit positions of the 16-bit compare condition vector
//   - cmp_cond_t: legal condition selectors (EQ=0 ... ORD=12)
//   - cmp_res_t : one buffered result {res, tag, exc, trap}
//   - cond_is_illegal(): true for selectors that name no condition (5,6,7,13,14,15)
package fpCmpPkg;

    localparam int unsigned CMP_RESW = 64;
    localparam int unsigned CMP_TAGW = 6;

    localparam int unsigned CMP_EQ_BIT     = 0;
    localparam int unsigned CMP_LT_BIT     = 1;
    localparam int unsigned CMP_LE_BIT     = 2;
    localparam int unsigned CMP_MAGLT_BIT  = 3;
    localparam int unsigned CMP_UNORD_BIT  = 4;
    localparam int unsigned CMP_NE_BIT     = 8;
    localparam int unsigned CMP_GE_BIT     = 9;
    localparam int unsigned CMP_GT_BIT     = 10;
    localparam int unsigned CMP_NMAGLT_BIT = 11;
    localparam int unsigned CMP_ORD_BIT    = 12;

    typedef enum logic [3:0] {
        EQ     = 4'(CMP_EQ_BIT),
        LT     = 4'(CMP_LT_BIT),
        LE     = 4'(CMP_LE_BIT),
        MAGLT  = 4'(CMP_MAGLT_BIT),
        UNORD  = 4'(CMP_UNORD_BIT),
        NE     = 4'(CMP_NE_BIT),
        GE     = 4'(CMP_GE_BIT),
        GT     = 4'(CMP_GT_BIT),
        NMAGLT = 4'(CMP_NMAGLT_BIT),
        ORD    = 4'(CMP_ORD_BIT)
    } cmp_cond_t;

    // The set-result is only ever 0 or 1, so one bit is stored per entry and
    // zero-extended on the way out.
    typedef struct packed {
        logic                res;
        logic [CMP_TAGW-1:0] tag;
        logic [1:0]          exc;   // {illegal, invalid}
        logic                trap;
    } cmp_res_t;

    function automatic logic cond_is_illegal(input logic [3:0] cond);
        return !(cond inside {EQ, LT, LE, MAGLT, UNORD, NE, GE, GT, NMAGLT, ORD});
    endfunction

endpackage

// File: rtl/fp_cmp_skid2.sv
// fp_cmp_skid2: 2-entry FIFO of type T with a registered ready.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   in_valid_i/in_ready_o push handshake; in_ready_o is a flop (no path from out_ready_i)
//   in_data_i             entry to push
//   out_valid_o           FIFO not empty
//   out_ready_i           pop the head when out_valid_o is high
//   out_data_o            head entry, stable while stalled
module fp_cmp_skid2
    import fpCmpPkg::*;
#(
    parameter type T = cmp_res_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    T           mem_q [2];
    logic       wptr_q, rptr_q;
    logic [1:0] cnt_q, cnt_d;
    logic       rdy_q;
    logic       push, pop;

    assign push        = in_valid_i & rdy_q;
    assign out_valid_o = (cnt_q != 2'd0);
    assign pop         = out_valid_o & out_ready_i;
    assign in_ready_o  = rdy_q;
    assign out_data_o  = mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (pop && !push) cnt_d = cnt_q - 2'd1;
    end

    // Ready follows next-cycle occupancy, so a pop while full only re-opens
    // the input one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= '0;
            rdy_q  <= 1'b1;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= in_data_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != 2'd2);
        end
    end

endmodule

// File: rtl/fp_cmp_result_unit.sv
// fp_cmp_result_unit: selects one condition from the FP64 compare vector,
// produces a 0/1 set-result, computes {illegal, invalid} exceptions, keeps
// sticky flags, and returns results through a 2-entry buffer.
// Configuration macro: FP_CMP_TRAP_EN (adds trap_en_i; otherwise trap_o = 0).
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   in_valid_i/in_ready_o      input handshake
//   cmp_i, nan_i, snan_i       compare vector and NaN flags
//   cond_i, sig_i, tag_i       condition select, signalling compare, opaque tag
//   out_valid_o/out_ready_i    output handshake
//   res_o, tag_o, exc_o        result, tag, per-result {illegal, invalid}
//   fflags_o, fflags_clr_i     sticky {illegal, invalid} and its clear
//   trap_en_i                  {illegal, invalid} trap enables (FP_CMP_TRAP_EN only)
//   trap_o                     trap request for the head entry
module fp_cmp_result_unit
    import fpCmpPkg::*;
#(
    parameter int unsigned RESW = CMP_RESW,
    parameter int unsigned TAGW = CMP_TAGW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [15:0]     cmp_i,
    input  logic            nan_i,
    input  logic            snan_i,
    input  logic [3:0]      cond_i,
    input  logic            sig_i,
    input  logic [TAGW-1:0] tag_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [RESW-1:0] res_o,
    output logic [TAGW-1:0] tag_o,
    output logic [1:0]      exc_o,
    output logic [1:0]      fflags_o,
    input  logic            fflags_clr_i,
`ifdef FP_CMP_TRAP_EN
    input  logic [1:0]      trap_en_i,
`endif
    output logic            trap_o
);

    cmp_res_t   entry, head;
    logic       illegal, invalid, accept;
    logic [1:0] fflags_q, fflags_d;

    assign illegal = cond_is_illegal(cond_i);
    assign invalid = sig_i ? nan_i : snan_i;
    assign accept  = in_valid_i & in_ready_o;

    always_comb begin
        entry     = '0;
        entry.res = cmp_i[cond_i] & ~illegal;
        entry.tag = tag_i;
        entry.exc = {illegal, invalid};
`ifdef FP_CMP_TRAP_EN
        entry.trap = |({illegal, invalid} & trap_en_i);
`else
        entry.trap = 1'b0;
`endif
    end

    fp_cmp_skid2 #(.T(cmp_res_t)) u_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (entry),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (head)
    );

    assign res_o  = {{(RESW-1){1'b0}}, head.res};
    assign tag_o  = head.tag;
    assign exc_o  = head.exc;
    assign trap_o = out_valid_o & head.trap;

    // Clear is applied before OR-ing in this cycle's exceptions so set wins.
    always_comb begin
        fflags_d = fflags_clr_i ? 2'b00 : fflags_q;
        if (accept) fflags_d = fflags_d | entry.exc;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fflags_q <= '0;
        else         fflags_q <= fflags_d;
    end

    assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fp_cmp_result_unit.sv
module tb_fp_cmp_result_unit;
    import fpCmpPkg::*;

    localparam int unsigned RESW = 64;
    localparam int unsigned TAGW = 6;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [15:0]     cmp_i = '0;
    logic            nan_i = 1'b0;
    logic            snan_i = 1'b0;
    logic [3:0]      cond_i = '0;
    logic            sig_i = 1'b0;
    logic [TAGW-1:0] tag_i = '0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b1;
    logic [RESW-1:0] res_o;
    logic [TAGW-1:0] tag_o;
    logic [1:0]      exc_o;
    logic [1:0]      fflags_o;
    logic            fflags_clr_i = 1'b0;
    logic            trap_o;
`ifdef FP_CMP_TRAP_EN
    logic [1:0]      trap_en_i = 2'b00;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fp_cmp_result_unit #(.RESW(RESW), .TAGW(TAGW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .cmp_i        (cmp_i),
        .nan_i        (nan_i),
        .snan_i       (snan_i),
        .cond_i       (cond_i),
        .sig_i        (sig_i),
        .tag_i        (tag_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .res_o        (res_o),
        .tag_o        (tag_o),
        .exc_o        (exc_o),
        .fflags_o     (fflags_o),
        .fflags_clr_i (fflags_clr_i),
`ifdef FP_CMP_TRAP_EN
        .trap_en_i    (trap_en_i),
`endif
        .trap_o       (trap_o)
    );

    // eq, le, ge, !maglt, ord set: bits 0,2,9,11,12
    localparam logic [15:0] CMP_EQUAL = 16'h1A05;

    // One beat accepted at the next posedge; returns at the following negedge
    // where the result is at the head (out_ready_i is left as the caller set it).
    task automatic send(input logic [15:0] cmp, input logic [3:0] cond, input logic sig,
                        input logic nan, input logic snan, input logic [TAGW-1:0] tag,
                        input logic clr);
        @(negedge clk);
        cmp_i = cmp; cond_i = cond; sig_i = sig; nan_i = nan; snan_i = snan;
        tag_i = tag; fflags_clr_i = clr; in_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0; fflags_clr_i = 1'b0;
    endtask

    task automatic clear_flags();
        @(negedge clk);
        fflags_clr_i = 1'b1;
        @(negedge clk);
        fflags_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        vectors++;
        if ({out_valid_o, res_o, tag_o, exc_o, fflags_o, trap_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b res=%0h tag=%0d exc=%b ff=%b trap=%b, want all 0",
                     out_valid_o, res_o, tag_o, exc_o, fflags_o, trap_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", in_ready_o);
        end
    endtask

    task automatic test_select();
        out_ready_i = 1'b1;
        send(CMP_EQUAL, 4'd0, 1'b0, 1'b0, 1'b0, 6'd3, 1'b0);
        vectors++;
        if (out_valid_o !== 1'b1 || res_o !== 64'd1 || tag_o !== 6'd3 || exc_o !== 2'b00) begin
            miscompares++;
            $display("FAIL sel_eq: got v=%b res=%0h tag=%0d exc=%b want v=1 res=1 tag=3 exc=00",
                     out_valid_o, res_o, tag_o, exc_o);
        end
        send(CMP_EQUAL, 4'd10, 1'b0, 1'b0, 1'b0, 6'd4, 1'b0);
        vectors++;
        if (res_o !== 64'd0 || exc_o !== 2'b00) begin
            miscompares++;
            $display("FAIL sel_gt: got res=%0h exc=%b want res=0 exc=00", res_o, exc_o);
        end
        send(CMP_EQUAL, 4'd11, 1'b0, 1'b0, 1'b0, 6'd5, 1'b0);
        vectors++;
        if (res_o !== 64'd1 || tag_o !== 6'd5) begin
            miscompares++;
            $display("FAIL sel_nmaglt: got res=%0h tag=%0d want res=1 tag=5", res_o, tag_o);
        end
        send(CMP_EQUAL, 4'd6, 1'b0, 1'b0, 1'b0, 6'd6, 1'b0);
        vectors++;
        if (res_o !== 64'd0 || exc_o !== 2'b10 || fflags_o !== 2'b10) begin
            miscompares++;
            $display("FAIL sel_illegal6: got res=%0h exc=%b ff=%b want res=0 exc=10 ff=10",
                     res_o, exc_o, fflags_o);
        end
        // illegal selector must force 0 even when that vector bit is set
        send(16'hFFFF, 4'd13, 1'b0, 1'b0, 1'b0, 6'd7, 1'b0);
        vectors++;
        if (res_o !== 64'd0 || exc_o !== 2'b10) begin
            miscompares++;
            $display("FAIL sel_illegal13: got res=%0h exc=%b want res=0 exc=10", res_o, exc_o);
        end
        send(16'hFFFF, 4'd12, 1'b0, 1'b0, 1'b0, 6'd63, 1'b0);
        vectors++;
        if (res_o !== 64'd1 || exc_o !== 2'b00 || tag_o !== 6'd63) begin
            miscompares++;
            $display("FAIL sel_ord_all1: got res=%0h exc=%b tag=%0d want res=1 exc=00 tag=63",
                     res_o, exc_o, tag_o);
        end
        clear_flags();
    endtask

    task automatic test_invalid();
        out_ready_i = 1'b1;
        send(16'h1010, 4'd4, 1'b0, 1'b1, 1'b0, 6'd8, 1'b0);
        vectors++;
        if (exc_o !== 2'b00 || res_o !== 64'd1 || fflags_o !== 2'b00) begin
            miscompares++;
            $display("FAIL qnan_quiet: got exc=%b res=%0h ff=%b want exc=00 res=1 ff=00",
                     exc_o, res_o, fflags_o);
        end
        send(16'h1010, 4'd4, 1'b1, 1'b1, 1'b0, 6'd9, 1'b0);
        vectors++;
        if (exc_o !== 2'b01 || fflags_o !== 2'b01) begin
            miscompares++;
            $display("FAIL qnan_signalling: got exc=%b ff=%b want exc=01 ff=01", exc_o, fflags_o);
        end
        send(16'h1010, 4'd4, 1'b0, 1'b1, 1'b1, 6'd10, 1'b0);
        vectors++;
        if (exc_o !== 2'b01) begin
            miscompares++;
            $display("FAIL snan_quiet: got exc=%b want 01", exc_o);
        end
        // sig=1 ignores snan alone: only nan_i decides
        send(16'h1010, 4'd4, 1'b1, 1'b0, 1'b1, 6'd11, 1'b0);
        vectors++;
        if (exc_o !== 2'b00) begin
            miscompares++;
            $display("FAIL sig_no_nan: got exc=%b want 00", exc_o);
        end
        clear_flags();
    endtask

    task automatic test_back_to_back();
        logic [TAGW-1:0] seen [$];
        @(negedge clk);
        out_ready_i = 1'b0;
        cmp_i = CMP_EQUAL; cond_i = 4'd0; sig_i = 1'b0; nan_i = 1'b0; snan_i = 1'b0;
        in_valid_i = 1'b1; tag_i = 6'd1;
        @(negedge clk);
        tag_i = 6'd2;
        @(negedge clk);
        tag_i = 6'd3;
        vectors++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || tag_o !== 6'd1) begin
            miscompares++;
            $display("FAIL full_ready: got rdy=%b v=%b tag=%0d want rdy=0 v=1 tag=1",
                     in_ready_o, out_valid_o, tag_o);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (in_ready_o !== 1'b0 || tag_o !== 6'd1 || res_o !== 64'd1) begin
            miscompares++;
            $display("FAIL stall_hold: got rdy=%b tag=%0d res=%0h want rdy=0 tag=1 res=1",
                     in_ready_o, tag_o, res_o);
        end
        out_ready_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            if (out_valid_o && out_ready_i) seen.push_back(tag_o);
            if (in_valid_i && in_ready_o) begin
                #1 in_valid_i = 1'b0;
            end
        end
        in_valid_i = 1'b0;
        vectors++;
        if (seen.size() != 3 || seen[0] !== 6'd1 || seen[1] !== 6'd2 || seen[2] !== 6'd3) begin
            miscompares++;
            $display("FAIL drain_order: got %0d beats %p want tags 1,2,3", seen.size(), seen);
        end
        @(negedge clk);
        vectors++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL drained_empty: got v=%b rdy=%b want v=0 rdy=1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_sticky();
        out_ready_i = 1'b1;
        send(CMP_EQUAL, 4'd7, 1'b0, 1'b0, 1'b0, 6'd12, 1'b0);
        send(CMP_EQUAL, 4'd0, 1'b0, 1'b0, 1'b1, 6'd13, 1'b0);
        vectors++;
        if (fflags_o !== 2'b11) begin
            miscompares++;
            $display("FAIL sticky_accum: got %b want 11", fflags_o);
        end
        send(CMP_EQUAL, 4'd0, 1'b1, 1'b1, 1'b0, 6'd14, 1'b1);
        vectors++;
        if (fflags_o !== 2'b01) begin
            miscompares++;
            $display("FAIL clr_and_set: got %b want 01", fflags_o);
        end
        clear_flags();
        vectors++;
        if (fflags_o !== 2'b00) begin
            miscompares++;
            $display("FAIL clr_alone: got %b want 00", fflags_o);
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        out_ready_i = 1'b0;
        cmp_i = CMP_EQUAL; cond_i = 4'd0; sig_i = 1'b0; nan_i = 1'b0; snan_i = 1'b1;
        tag_i = 6'd20; in_valid_i = 1'b1;
        @(negedge clk);
        tag_i = 6'd21;
        @(negedge clk);
        in_valid_i = 1'b0;
        vectors++;
        if (out_valid_o !== 1'b1 || fflags_o !== 2'b01 || in_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset_full: got v=%b ff=%b rdy=%b want v=1 ff=01 rdy=0",
                     out_valid_o, fflags_o, in_ready_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        vectors++;
        if (out_valid_o !== 1'b0 || fflags_o !== 2'b00 || tag_o !== 6'd0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b ff=%b tag=%0d want v=0 ff=00 tag=0",
                     out_valid_o, fflags_o, tag_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset: got v=%b rdy=%b want v=0 rdy=1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_trap();
`ifdef FP_CMP_TRAP_EN
        out_ready_i = 1'b1;
        trap_en_i = 2'b01;
        send(16'h1010, 4'd4, 1'b1, 1'b1, 1'b0, 6'd30, 1'b0);
        vectors++;
        if (trap_o !== 1'b1 || tag_o !== 6'd30) begin
            miscompares++;
            $display("FAIL trap_invalid: got trap=%b tag=%0d want trap=1 tag=30", trap_o, tag_o);
        end
        send(CMP_EQUAL, 4'd5, 1'b0, 1'b0, 1'b0, 6'd31, 1'b0);
        vectors++;
        if (trap_o !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_masked: got trap=%b want 0", trap_o);
        end
        trap_en_i = 2'b00;
        clear_flags();
`else
        // trap enables absent: even an invalid result must not request a trap
        out_ready_i = 1'b1;
        send(16'h1010, 4'd4, 1'b1, 1'b1, 1'b0, 6'd30, 1'b0);
        vectors++;
        if (trap_o !== 1'b0 || out_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL trap_tied: got trap=%b v=%b want trap=0 v=1", trap_o, out_valid_o);
        end
        clear_flags();
`endif
    endtask

    initial begin
        test_reset();
        test_select();
        test_invalid();
        test_back_to_back();
        test_sticky();
        test_trap();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule
